alu32: RTL and testbench

32-bit registered integer ALU for the single-cycle/pipelined datapath execute stage. It performs AND, OR, ADD, SUB, NOR, NAND and a family of signed set-on-compare operations. Results and status flags (zero, carry-out, overflow) are captured on the clock edge.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_bit.sv | 24 ++
 rtl/alu32.sv | 64 ++++++
 tb/tb_alu32.sv | 135 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode and compare-select constants for the alu32 datapath
package alu_pkg;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NAND = 4'b1101;
  localparam logic [2:0] CMP_LT = 3'b000;
  localparam logic [2:0] CMP_GT = 3'b001;
  localparam logic [2:0] CMP_LE = 3'b010;
  localparam logic [2:0] CMP_GE = 3'b011;
  localparam logic [2:0] CMP_EQ = 3'b110;
  localparam logic [2:0] CMP_NE = 3'b100;
endpackage

// File: rtl/alu_bit.sv
// alu_bit: 1-bit ALU slice (a_i,b_i,binv_i,cin_i,op_i -> r_o,cout_o) doing and/or/nor/nand/full-add
module alu_bit
  import alu_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       binv_i,
  input  logic       cin_i,
  input  logic [3:0] op_i,
  output logic       r_o,
  output logic       cout_o
);
  logic bb, s;
  always_comb begin
    bb = b_i ^ binv_i;
    s = a_i ^ bb ^ cin_i;
    cout_o = (a_i & bb) | (cin_i & (a_i ^ bb));
    r_o = op_i == ALU_AND  ? a_i & b_i :
          op_i == ALU_OR   ? a_i | b_i :
          op_i == ALU_NOR  ? ~(a_i | b_i) :
          op_i == ALU_NAND ? ~(a_i & b_i) :
          (op_i == ALU_ADD || op_i == ALU_SUB || op_i == ALU_SLT) ? s : 1'b0;
  end
endmodule

// File: rtl/alu32.sv
// alu32: registered 32-bit ALU (clk,rst,src1,src2,ALU_control,bonus_control -> result,zero,cout,overflow)
module alu32
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ALU_control,
  input  logic [2:0]       bonus_control,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);
  logic [WIDTH-1:0] r, result_d, result_q;
  logic [WIDTH:0] c;
  logic binv, arith, v, less, eq, cond;
  logic zero_d, zero_q, cout_d, cout_q, ovf_d, ovf_q;
  assign binv = ALU_control == ALU_SUB || ALU_control == ALU_SLT;
  assign c[0] = binv;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    alu_bit u_bit (
      .a_i(src1[i]), .b_i(src2[i]), .binv_i(binv), .cin_i(c[i]),
      .op_i(ALU_control), .r_o(r[i]), .cout_o(c[i+1])
    );
  end
  always_comb begin
    arith = ALU_control == ALU_ADD || ALU_control == ALU_SUB;
    // r[msb] is the adder sign for ADD/SUB/SLT, the only ops that consume v
    v = (src1[WIDTH-1] == (src2[WIDTH-1] ^ binv)) && (r[WIDTH-1] != src1[WIDTH-1]);
    less = r[WIDTH-1] ^ v;
    eq = src1 == src2;
    cond = bonus_control == CMP_LT ? less :
           bonus_control == CMP_GT ? ~less & ~eq :
           bonus_control == CMP_LE ? less | eq :
           bonus_control == CMP_GE ? ~less :
           bonus_control == CMP_EQ ? eq :
           bonus_control == CMP_NE ? ~eq : 1'b0;
    result_d = ALU_control == ALU_SLT ? {{(WIDTH-1){1'b0}}, cond} : r;
    zero_d = result_d == '0;
    cout_d = arith & c[WIDTH];
    ovf_d = arith & v;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      zero_q <= 1'b1;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q <= zero_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
    end
  end
  assign result = result_q;
  assign zero = zero_q;
  assign cout = cout_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_alu32.sv
// tb_alu32: scoreboard bench for alu32
module tb_alu32;
  import alu_pkg::*;
  typedef struct {logic [31:0] r; logic z, c, v;} exp_t;
  logic clk = 0, rst = 1;
  logic [31:0] src1 = 0, src2 = 0, result;
  logic [3:0] ALU_control = 0;
  logic [2:0] bonus_control = 0;
  logic zero, cout, overflow;
  int checks = 0, errors = 0;
  exp_t q[$];
  alu32 dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .ALU_control(ALU_control),
    .bonus_control(bonus_control), .result(result), .zero(zero), .cout(cout), .overflow(overflow)
  );
  always #5 clk = ~clk;
  function automatic exp_t model(logic [3:0] op, logic [2:0] bc, logic [31:0] a, logic [31:0] b);
    exp_t e;
    longint sa, sb, t;
    logic [32:0] w;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.r = 0; e.c = 0; e.v = 0;
    if (op == ALU_AND) e.r = a & b;
    else if (op == ALU_OR) e.r = a | b;
    else if (op == ALU_NOR) e.r = ~(a | b);
    else if (op == ALU_NAND) e.r = ~(a & b);
    else if (op == ALU_ADD) begin
      w = {1'b0, a} + {1'b0, b}; t = sa + sb;
      e.r = w[31:0]; e.c = w[32]; e.v = t > 64'sd2147483647 || t < -64'sd2147483648;
    end else if (op == ALU_SUB) begin
      w = {1'b0, a} + {1'b0, ~b} + 33'd1; t = sa - sb;
      e.r = w[31:0]; e.c = w[32]; e.v = t > 64'sd2147483647 || t < -64'sd2147483648;
    end else if (op == ALU_SLT)
      e.r = {31'b0, bc == CMP_LT ? sa < sb : bc == CMP_GT ? sa > sb : bc == CMP_LE ? sa <= sb :
                    bc == CMP_GE ? sa >= sb : bc == CMP_EQ ? sa == sb : bc == CMP_NE ? sa != sb : 1'b0};
    e.z = e.r == 0;
    return e;
  endfunction
  task automatic drive(logic [3:0] op, logic [2:0] bc, logic [31:0] a, logic [31:0] b, exp_t e);
    @(negedge clk);
    ALU_control = op; bonus_control = bc; src1 = a; src2 = b;
    q.push_back(e);
  endtask
  task automatic test_reset;
    exp_t e;
    drive(ALU_OR, 0, 32'h1234_0000, 32'h0000_5678, '{32'h1234_5678, 0, 0, 0});
    rst = 0;
    @(posedge clk); #1;
    e = q.pop_front();
    checks++;
    if (result !== e.r || zero !== e.z) begin errors++; $display("FAIL pre_reset result=%h z=%b want %h z=%b", result, zero, e.r, e.z); end
    #2 rst = 1; #1;
    checks++;
    if ({result, zero, cout, overflow} !== {32'h0, 3'b100}) begin errors++; $display("FAIL async_reset got %h z%b c%b v%b want 00000000 z1 c0 v0", result, zero, cout, overflow); end
    ALU_control = ALU_ADD; src1 = 32'hffffffff; src2 = 32'h1;
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({result, zero, cout, overflow} !== {32'h0, 3'b100}) begin errors++; $display("FAIL reset_hold got %h z%b c%b v%b want 00000000 z1 c0 v0", result, zero, cout, overflow); end
    @(negedge clk) rst = 0;
  endtask
  task automatic test_ops;
    exp_t e;
    logic [3:0] op[9] = '{ALU_AND, ALU_OR, ALU_NAND, ALU_ADD, ALU_ADD, ALU_SUB, ALU_NOR, 4'b0011, ALU_SUB};
    logic [31:0] a[9] = '{32'hffff0000, 32'h3113c398, 32'h11111111, 32'hffffffff, 32'h7fffffff, 32'h7eda5023, 32'h0f0f0000, 32'hdeadbeef, 32'h80000000};
    logic [31:0] b[9] = '{32'h0000ffff, 32'h088e4954, 32'h11111111, 32'h00000001, 32'h00000001, 32'h2ec36ae5, 32'h00f0f0f0, 32'h12345678, 32'h00000001};
    exp_t x[9] = '{'{32'h00000000, 1, 0, 0}, '{32'h399fcbdc, 0, 0, 0}, '{32'heeeeeeee, 0, 0, 0},
                   '{32'h00000000, 1, 1, 0}, '{32'h80000000, 0, 0, 1}, '{32'h5016e53e, 0, 1, 0},
                   '{32'hf0000f0f, 0, 0, 0}, '{32'h00000000, 1, 0, 0}, '{32'h7fffffff, 0, 1, 1}};
    for (int i = 0; i < 9; i++) begin
      drive(op[i], CMP_EQ, a[i], b[i], x[i]);
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (result !== e.r || zero !== e.z || cout !== e.c || overflow !== e.v) begin
        errors++;
        $display("FAIL op%0d got %h z%b c%b v%b want %h z%b c%b v%b", i, result, zero, cout, overflow, e.r, e.z, e.c, e.v);
      end
    end
  endtask
  task automatic test_back_to_back;
    exp_t e;
    logic [2:0] bc[7] = '{CMP_LT, CMP_EQ, CMP_GE, CMP_LE, CMP_GT, CMP_NE, 3'b101};
    logic [31:0] a[7] = '{32'hffffffff, 32'h78563412, 32'h7fee3c5b, 32'h787207f7, 32'h4760ee5a, 32'h11111111, 32'h00000001};
    logic [31:0] b[7] = '{32'h00000001, 32'h78563412, 32'h71bcbbfa, 32'h066926e8, 32'h07c09267, 32'h11111111, 32'h00000005};
    logic x[7] = '{1, 1, 1, 0, 1, 0, 0};
    for (int i = 0; i < 7; i++) begin
      drive(ALU_SLT, bc[i], a[i], b[i], '{{31'b0, x[i]}, !x[i], 0, 0});
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (result !== e.r || zero !== e.z || cout !== e.c || overflow !== e.v) begin
        errors++;
        $display("FAIL cmp%0d got %h z%b c%b v%b want %h z%b c%b v%b", i, result, zero, cout, overflow, e.r, e.z, e.c, e.v);
      end
    end
  endtask
  task automatic test_hold;
    drive(ALU_ADD, 0, 32'h00000010, 32'h00000020, '{32'h30, 0, 0, 0});
    @(posedge clk); #1;
    void'(q.pop_front());
    ALU_control = ALU_NOR; src1 = 0; src2 = 0; bonus_control = CMP_NE;
    #3;
    checks++;
    if (result !== 32'h30 || zero !== 0) begin errors++; $display("FAIL hold got %h z%b want 00000030 z0", result, zero); end
  endtask
  task automatic test_random;
    exp_t e;
    logic [3:0] ops[8] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_NAND, 4'b1111};
    logic [31:0] a, b;
    for (int i = 0; i < 200; i++) begin
      a = $urandom; b = (i % 5 == 0) ? a : $urandom;
      if (i % 7 == 0) b = {~a[31], $urandom_range(0, 1000)};
      drive(ops[$urandom_range(0, 7)], 3'($urandom_range(0, 7)), a, b, '{0, 0, 0, 0});
      q[q.size()-1] = model(ALU_control, bonus_control, a, b);
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (result !== e.r || zero !== e.z || cout !== e.c || overflow !== e.v) begin
        errors++;
        $display("FAIL rnd%0d op%b bc%b a=%h b=%h got %h z%b c%b v%b want %h z%b c%b v%b", i, ALU_control, bonus_control, a, b,
                 result, zero, cout, overflow, e.r, e.z, e.c, e.v);
      end
    end
  endtask
  initial begin
    test_reset;
    test_ops;
    test_back_to_back;
    test_hold;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
